dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 8, meaning the maximum number of consecutive core grants allowed while a debug request waits.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port areset  input  1  asynchronous reset, active-high.
REQ-004 SHALL have port i_core_req  input  1  core (LSU) request valid.
REQ-005 SHALL have core request ports: i_core_cmd input 1 (0 = load, 1 = store); i_core_addr input XLEN; i_core_size input 2 (BYTE/HWORD/WORD); i_core_data input XLEN.
REQ-006 SHALL have core response ports: o_core_done output 1 (single-cycle pulse, transaction complete); o_core_rdata output XLEN; o_core_stall output 1.
REQ-007 SHALL have debug request ports i_dbg_req, i_dbg_cmd, i_dbg_addr, i_dbg_size, i_dbg_data, with the same widths and meanings as the core ports.
REQ-008 SHALL have debug response ports o_dbg_done output 1 and o_dbg_rdata output XLEN.
REQ-009 SHALL have memory request ports: o_mem_req output 1; o_mem_cmd output 1; o_mem_addr output XLEN; o_mem_size output 2; o_mem_data output XLEN.
REQ-010 SHALL have memory handshake ports: i_mem_ready input 1 (request accepted); i_mem_rvalid input 1 (load data valid); i_mem_rdata input XLEN.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, CORE_BUSY, DBG_BUSY.
REQ-012 In IDLE, grant selection SHALL be: core only if only core requests; debug only if only debug requests; if both request, core wins unless starve_cnt == STARVE_MAX, in which case debug wins.
REQ-013 A grant at cycle N SHALL register the winner's cmd/addr/size/data into the o_mem_* outputs and assert o_mem_req from cycle N+1.
REQ-014 o_mem_* outputs SHALL hold stable while o_mem_req = 1 && i_mem_ready = 0.
REQ-015 o_mem_req SHALL deassert in the cycle after o_mem_req && i_mem_ready.
REQ-016 A store SHALL complete on acceptance: o_*_done pulses in the cycle after acceptance, and the FSM returns to IDLE.
REQ-017 A load SHALL wait after acceptance for i_mem_rvalid. On rvalid, i_mem_rdata SHALL be registered into the owner's o_*_rdata, o_*_done SHALL pulse the next cycle, and the FSM returns to IDLE.
REQ-018 i_mem_rvalid SHALL be ignored in IDLE, and before acceptance of the current request.
REQ-019 o_*_rdata SHALL hold its last value until the next load completes for that owner; it is unchanged on stores.
REQ-020 o_core_stall SHALL be high whenever i_core_req = 1 and the core's transaction has not yet completed; it SHALL fall in the same cycle o_core_done pulses.
REQ-021 starve_cnt SHALL increment, saturating at STARVE_MAX, on each core grant made while i_dbg_req = 1.
REQ-022 starve_cnt SHALL clear on any debug grant, or whenever i_dbg_req = 0 in IDLE.
REQ-023 One outstanding transaction at most; requests arriving while busy SHALL wait and be re-evaluated in IDLE.
REQ-024 A done pulse and a new grant MAY occur in the same cycle, giving back-to-back throughput of one transaction per two cycles minimum.
REQ-025 Requesters SHALL hold req and payload until done; a requester deasserting req before done SHALL NOT abort the transaction in flight.
REQ-026 i_*_size = 2'b11 SHALL be forwarded unchanged; address alignment is not checked here.

Reset
REQ-027 On areset, the FSM SHALL enter IDLE, starve_cnt SHALL = 0, and o_mem_req, o_mem_cmd, o_core_done, o_dbg_done SHALL = 0.
REQ-028 On areset, o_mem_size SHALL = BYTE, and o_mem_addr, o_mem_data, o_core_rdata, o_dbg_rdata SHALL = 0.
REQ-029 On areset, o_core_stall SHALL follow REQ-020 combinationally.
REQ-030 Reset mid-transaction SHALL drop it silently; no done pulse SHALL follow.

Structure
REQ-031 The FSM state enum and the BYTE/HWORD/WORD and LOAD/STORE constants SHALL live in pqr5_core_pkg.
REQ-032 XLEN SHALL come from the core macros header.
REQ-033 A single sub-module, dmem_prio_sel (combinational grant selection plus starve counter), SHALL be used; everything else is flat.

Verification
REQ-034 Core store, addr 0x100, data 0xDEADBEEF, WORD, i_mem_ready tied high -> o_mem_req one cycle with matching payload; o_core_done 2 cycles after grant; o_core_stall low afterwards.
REQ-035 Core load, addr 0x40, i_mem_ready delayed 3 cycles, rvalid 2 cycles after accept with 0x12345678 -> payload stable throughout; o_core_rdata = 0x12345678 with done pulse.
REQ-036 Core and debug requesting continuously, STARVE_MAX = 8 -> exactly 8 core grants, then 1 debug grant, repeating; starve_cnt never exceeds 8.
REQ-037 Debug-only load, addr 0x8, rdata 0xA5A5A5A5 -> o_dbg_rdata updated, o_core_rdata unchanged, o_core_stall low.
REQ-038 areset asserted while a load waits for rvalid, then rvalid arrives -> no done pulse; all outputs at reset values; next request serviced normally.
REQ-039 Spurious i_mem_rvalid in IDLE -> no rdata update, no done pulse.

Source files
------------

// File: rtl/pqr5_core_pkg.sv
// pqr5 core shared definitions.
//
// The first block is the core macros header. It sets the machine word width
// (PQR5_XLEN). It has an include guard so that a second inclusion is harmless.
//
// The package that follows holds:
//   - XLEN, the datapath width taken from PQR5_XLEN.
//   - arb_state_e, the data-memory arbiter state encoding.
//   - The access-size constants: SIZE_BYTE, SIZE_HWORD and SIZE_WORD.
//   - The command constants: CMD_LOAD and CMD_STORE.

`ifndef PQR5_CORE_MACROS
`define PQR5_CORE_MACROS
`define PQR5_XLEN 32
`endif

package pqr5_core_pkg;

  localparam int XLEN = `PQR5_XLEN;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CORE_BUSY = 2'd1,
    ST_DBG_BUSY  = 2'd2
  } arb_state_e;

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HWORD = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;

  localparam logic CMD_LOAD  = 1'b0;
  localparam logic CMD_STORE = 1'b1;

endpackage

// File: rtl/dmem_prio_sel.sv
// Grant selection and anti-starvation counter for the data-memory arbiter.
//
// The core normally wins when both requesters ask at the same time. The
// counter records how many core grants in a row were made while debug was
// waiting. When it reaches STARVE_MAX, debug wins the next contested slot.
//
// Ports:
//   clk, areset    : clock and asynchronous active-high reset.
//   idle_i         : high when the arbiter can issue a grant this cycle.
//   core_req_i     : core request valid.
//   dbg_req_i      : debug request valid.
//   grant_core_o   : the core is granted this cycle (combinational).
//   grant_dbg_o    : debug is granted this cycle (combinational).

module dmem_prio_sel #(
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic areset,
  input  logic idle_i,
  input  logic core_req_i,
  input  logic dbg_req_i,
  output logic grant_core_o,
  output logic grant_dbg_o
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             starve_full;

  assign starve_full = (starve_cnt_q == CNT_MAX);

  // Debug wins if it is the only requester, or if the core has already used
  // up its allowance of consecutive grants.
  assign grant_dbg_o  = idle_i && dbg_req_i && (!core_req_i || starve_full);
  assign grant_core_o = idle_i && core_req_i && !grant_dbg_o;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (idle_i) begin
      if (grant_dbg_o || !dbg_req_i) begin
        starve_cnt_d = '0;
      end else if (grant_core_o && !starve_full) begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter. It shares one memory port between the core LSU and
// the debug module.
//
// Only one transaction is in flight at a time. The winner's request is
// copied into the o_mem_* registers, which then stay stable until memory
// accepts the request.
//   - A store completes on acceptance.
//   - A load completes on the first i_mem_rvalid after acceptance.
// On completion, the owner's done output pulses for one cycle and the
// arbiter returns to IDLE. It can issue a new grant in that same cycle.
//
// Ports:
//   clk, areset                     : clock and asynchronous active-high reset.
//   i_core_req/cmd/addr/size/data   : core request channel.
//   o_core_done/rdata/stall         : core response channel.
//   i_dbg_req/cmd/addr/size/data    : debug request channel.
//   o_dbg_done/rdata                : debug response channel.
//   o_mem_req/cmd/addr/size/data    : memory request channel.
//   i_mem_ready                     : memory accepted the request.
//   i_mem_rvalid, i_mem_rdata       : memory load data return.

module dmem_arbiter
  import pqr5_core_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            areset,

  input  logic            i_core_req,
  input  logic            i_core_cmd,
  input  logic [XLEN-1:0] i_core_addr,
  input  logic [1:0]      i_core_size,
  input  logic [XLEN-1:0] i_core_data,
  output logic            o_core_done,
  output logic [XLEN-1:0] o_core_rdata,
  output logic            o_core_stall,

  input  logic            i_dbg_req,
  input  logic            i_dbg_cmd,
  input  logic [XLEN-1:0] i_dbg_addr,
  input  logic [1:0]      i_dbg_size,
  input  logic [XLEN-1:0] i_dbg_data,
  output logic            o_dbg_done,
  output logic [XLEN-1:0] o_dbg_rdata,

  output logic            o_mem_req,
  output logic            o_mem_cmd,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [1:0]      o_mem_size,
  output logic [XLEN-1:0] o_mem_data,
  input  logic            i_mem_ready,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata
);

  arb_state_e      state_q,      state_d;
  logic            accepted_q,   accepted_d;
  logic            mem_req_q,    mem_req_d;
  logic            mem_cmd_q,    mem_cmd_d;
  logic [XLEN-1:0] mem_addr_q,   mem_addr_d;
  logic [1:0]      mem_size_q,   mem_size_d;
  logic [XLEN-1:0] mem_data_q,   mem_data_d;
  logic            core_done_q,  core_done_d;
  logic            dbg_done_q,   dbg_done_d;
  logic [XLEN-1:0] core_rdata_q, core_rdata_d;
  logic [XLEN-1:0] dbg_rdata_q,  dbg_rdata_d;

  logic grant_core;
  logic grant_dbg;
  logic owner_is_core;

  dmem_prio_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio_sel (
    .clk          (clk),
    .areset       (areset),
    .idle_i       (state_q == ST_IDLE),
    .core_req_i   (i_core_req),
    .dbg_req_i    (i_dbg_req),
    .grant_core_o (grant_core),
    .grant_dbg_o  (grant_dbg)
  );

  assign owner_is_core = (state_q == ST_CORE_BUSY);

  always_comb begin
    state_d      = state_q;
    accepted_d   = accepted_q;
    mem_req_d    = mem_req_q;
    mem_cmd_d    = mem_cmd_q;
    mem_addr_d   = mem_addr_q;
    mem_size_d   = mem_size_q;
    mem_data_d   = mem_data_q;
    core_rdata_d = core_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    core_done_d  = 1'b0;
    dbg_done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // i_mem_rvalid has no owner here and is deliberately ignored.
        if (grant_core) begin
          state_d    = ST_CORE_BUSY;
          accepted_d = 1'b0;
          mem_req_d  = 1'b1;
          mem_cmd_d  = i_core_cmd;
          mem_addr_d = i_core_addr;
          mem_size_d = i_core_size;
          mem_data_d = i_core_data;
        end else if (grant_dbg) begin
          state_d    = ST_DBG_BUSY;
          accepted_d = 1'b0;
          mem_req_d  = 1'b1;
          mem_cmd_d  = i_dbg_cmd;
          mem_addr_d = i_dbg_addr;
          mem_size_d = i_dbg_size;
          mem_data_d = i_dbg_data;
        end
      end

      ST_CORE_BUSY, ST_DBG_BUSY: begin
        if (!accepted_q) begin
          // Before acceptance, rvalid may belong to an earlier transaction,
          // so only the ready handshake is looked at.
          if (mem_req_q && i_mem_ready) begin
            mem_req_d = 1'b0;
            if (mem_cmd_q == CMD_STORE) begin
              state_d     = ST_IDLE;
              core_done_d = owner_is_core;
              dbg_done_d  = !owner_is_core;
            end else begin
              accepted_d = 1'b1;
            end
          end
        end else if (i_mem_rvalid) begin
          state_d    = ST_IDLE;
          accepted_d = 1'b0;
          if (owner_is_core) begin
            core_rdata_d = i_mem_rdata;
            core_done_d  = 1'b1;
          end else begin
            dbg_rdata_d = i_mem_rdata;
            dbg_done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d    = ST_IDLE;
        accepted_d = 1'b0;
        mem_req_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      accepted_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_cmd_q    <= CMD_LOAD;
      mem_addr_q   <= '0;
      mem_size_q   <= SIZE_BYTE;
      mem_data_q   <= '0;
      core_done_q  <= 1'b0;
      dbg_done_q   <= 1'b0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      accepted_q   <= accepted_d;
      mem_req_q    <= mem_req_d;
      mem_cmd_q    <= mem_cmd_d;
      mem_addr_q   <= mem_addr_d;
      mem_size_q   <= mem_size_d;
      mem_data_q   <= mem_data_d;
      core_done_q  <= core_done_d;
      dbg_done_q   <= dbg_done_d;
      core_rdata_q <= core_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign o_mem_req    = mem_req_q;
  assign o_mem_cmd    = mem_cmd_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_size   = mem_size_q;
  assign o_mem_data   = mem_data_q;
  assign o_core_done  = core_done_q;
  assign o_dbg_done   = dbg_done_q;
  assign o_core_rdata = core_rdata_q;
  assign o_dbg_rdata  = dbg_rdata_q;

  // Stall drops in the same cycle that done pulses, because the requester
  // samples both outputs together.
  assign o_core_stall = i_core_req && !core_done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter.
//
// A transaction-level reference model predicts, for every cycle:
//   - which requester is granted;
//   - the request presented to memory;
//   - when done pulses, and which rdata value each owner holds.
// Two requester agents and a memory agent drive random traffic. That
// traffic includes spurious rvalid pulses, all four size encodings, requests
// abandoned mid-flight, and resets asserted mid-transaction.

module tb_dmem_arbiter;
  import pqr5_core_pkg::*;

  localparam int SMAX = 8;

  logic            clk = 1'b0;
  logic            areset = 1'b0;
  logic            core_req = 1'b0, core_cmd = 1'b0;
  logic [XLEN-1:0] core_addr = '0, core_data = '0;
  logic [1:0]      core_size = '0;
  logic            dbg_req = 1'b0, dbg_cmd = 1'b0;
  logic [XLEN-1:0] dbg_addr = '0, dbg_data = '0;
  logic [1:0]      dbg_size = '0;
  logic            mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;

  logic            o_core_done, o_core_stall, o_dbg_done;
  logic [XLEN-1:0] o_core_rdata, o_dbg_rdata;
  logic            o_mem_req, o_mem_cmd;
  logic [XLEN-1:0] o_mem_addr, o_mem_data;
  logic [1:0]      o_mem_size;

  dmem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk          (clk),
    .areset       (areset),
    .i_core_req   (core_req),
    .i_core_cmd   (core_cmd),
    .i_core_addr  (core_addr),
    .i_core_size  (core_size),
    .i_core_data  (core_data),
    .o_core_done  (o_core_done),
    .o_core_rdata (o_core_rdata),
    .o_core_stall (o_core_stall),
    .i_dbg_req    (dbg_req),
    .i_dbg_cmd    (dbg_cmd),
    .i_dbg_addr   (dbg_addr),
    .i_dbg_size   (dbg_size),
    .i_dbg_data   (dbg_data),
    .o_dbg_done   (o_dbg_done),
    .o_dbg_rdata  (o_dbg_rdata),
    .o_mem_req    (o_mem_req),
    .o_mem_cmd    (o_mem_cmd),
    .o_mem_addr   (o_mem_addr),
    .o_mem_size   (o_mem_size),
    .o_mem_data   (o_mem_data),
    .i_mem_ready  (mem_ready),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model. phase: 0 = free, 1 = request presented, 2 = load accepted.
  int              m_phase = 0;
  bit              m_owner_dbg = 1'b0;
  int              m_starve = 0;
  bit              exp_req = 1'b0, exp_cmd = 1'b0;
  logic [XLEN-1:0] exp_addr = '0, exp_data = '0;
  logic [1:0]      exp_size = '0;
  bit              exp_cdone = 1'b0, exp_ddone = 1'b0;
  logic [XLEN-1:0] exp_crd = '0, exp_drd = '0;

  // Requester agent state: a transaction is wanted / in flight.
  bit c_active = 1'b0, d_active = 1'b0;

  // Starvation pattern bookkeeping.
  int core_run = 0;
  int dbg_seen = 0;

  task automatic model_reset();
    m_phase = 0; m_owner_dbg = 1'b0; m_starve = 0;
    exp_req = 1'b0; exp_cmd = 1'b0; exp_addr = '0; exp_data = '0; exp_size = SIZE_BYTE;
    exp_cdone = 1'b0; exp_ddone = 1'b0; exp_crd = '0; exp_drd = '0;
  endtask

  // Apply the arbitration rules to the inputs that will be sampled at the
  // next rising edge.
  task automatic model_step();
    bit cd, dd, gc, gd;
    cd = 1'b0; dd = 1'b0;
    if (m_phase == 0) begin
      gd = dbg_req && (!core_req || (m_starve == SMAX));
      gc = core_req && !gd;
      if (gd || !dbg_req) m_starve = 0;
      else if (gc && m_starve < SMAX) m_starve++;
      if (gc || gd) begin
        m_owner_dbg = gd;
        exp_req  = 1'b1;
        exp_cmd  = gd ? dbg_cmd  : core_cmd;
        exp_addr = gd ? dbg_addr : core_addr;
        exp_size = gd ? dbg_size : core_size;
        exp_data = gd ? dbg_data : core_data;
        m_phase  = 1;
      end
    end else if (m_phase == 1) begin
      if (mem_ready) begin
        exp_req = 1'b0;
        if (exp_cmd == CMD_STORE) begin
          cd = !m_owner_dbg; dd = m_owner_dbg; m_phase = 0;
        end else begin
          m_phase = 2;
        end
      end
    end else begin
      if (mem_rvalid) begin
        if (m_owner_dbg) begin exp_drd = mem_rdata; dd = 1'b1; end
        else             begin exp_crd = mem_rdata; cd = 1'b1; end
        m_phase = 0;
      end
    end
    exp_cdone = cd;
    exp_ddone = dd;
  endtask

  task automatic check_outputs();
    check_val("mem_req", o_mem_req, exp_req);
    if (exp_req) begin
      check_val("mem_cmd_size", {o_mem_cmd, o_mem_size}, {exp_cmd, exp_size});
      check_val("mem_addr", o_mem_addr, exp_addr);
      check_val("mem_data", o_mem_data, exp_data);
    end
    check_val("core_done", o_core_done, exp_cdone);
    check_val("dbg_done", o_dbg_done, exp_ddone);
    check_val("core_rdata", o_core_rdata, exp_crd);
    check_val("dbg_rdata", o_dbg_rdata, exp_drd);
    check_val("core_stall", o_core_stall, core_req && !exp_cdone);
  endtask

  task automatic check_reset_values();
    check_val("rst_mem_req", o_mem_req, 1'b0);
    check_val("rst_mem_cmd_size", {o_mem_cmd, o_mem_size}, {CMD_LOAD, SIZE_BYTE});
    check_val("rst_mem_addr", o_mem_addr, '0);
    check_val("rst_mem_data", o_mem_data, '0);
    check_val("rst_dones", {o_core_done, o_dbg_done}, 2'b00);
    check_val("rst_core_rdata", o_core_rdata, '0);
    check_val("rst_dbg_rdata", o_dbg_rdata, '0);
    check_val("rst_core_stall", o_core_stall, core_req);
  endtask

  // Called away from the clock edge; asserts reset asynchronously.
  task automatic do_reset();
    areset = 1'b1;
    #1;
    model_reset();
    check_reset_values();
    repeat (2) begin
      @(posedge clk); #1;
      check_reset_values();
    end
    areset = 1'b0;
  endtask

  task automatic drive_agents(input int p_core, input int p_dbg, input int p_ready,
                              input int p_rv, input int p_drop);
    if (exp_cdone) c_active = 1'b0;
    if (exp_ddone) d_active = 1'b0;
    // An abandoned request still completes inside the arbiter.
    if (c_active && $urandom_range(0, 99) < p_drop) c_active = 1'b0;
    if (d_active && $urandom_range(0, 99) < p_drop) d_active = 1'b0;
    if (!c_active && $urandom_range(0, 99) < p_core) c_active = 1'b1;
    if (!d_active && $urandom_range(0, 99) < p_dbg) d_active = 1'b1;
    // Payload is only held while a request is wanted.
    if (!core_req || !c_active || exp_cdone) begin
      core_cmd  = 1'($urandom_range(0, 1));
      core_addr = $urandom;
      core_size = 2'($urandom_range(0, 3));
      core_data = $urandom;
    end
    if (!dbg_req || !d_active || exp_ddone) begin
      dbg_cmd  = 1'($urandom_range(0, 1));
      dbg_addr = $urandom;
      dbg_size = 2'($urandom_range(0, 3));
      dbg_data = $urandom;
    end
    core_req   = c_active;
    dbg_req    = d_active;
    mem_ready  = ($urandom_range(0, 99) < p_ready);
    mem_rvalid = ($urandom_range(0, 99) < p_rv);
    mem_rdata  = $urandom;
  endtask

  task automatic run_cycles(input int n, input int p_core, input int p_dbg, input int p_ready,
                            input int p_rv, input int p_drop, input bit track_starve);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge clk); #1;
      check_outputs();
      if (track_starve) begin
        if (o_core_done) core_run++;
        if (o_dbg_done) begin
          check_val("starve_run", core_run, SMAX);
          core_run = 0;
          dbg_seen++;
        end
      end
      drive_agents(p_core, p_dbg, p_ready, p_rv, p_drop);
    end
  endtask

  initial begin
    int k;
    #2;
    do_reset();

    // Mixed traffic with slow memory, spurious rvalid and occasional aborts.
    run_cycles(400, 30, 30, 60, 30, 2, 1'b0);
    // Mostly debug-only traffic with the core quiet.
    run_cycles(200, 3, 40, 50, 40, 0, 1'b0);
    // Heavy contention with slow acceptance.
    run_cycles(300, 60, 60, 30, 40, 0, 1'b0);

    // Hold off rvalid until a load is waiting for data, then reset.
    k = 0;
    while (m_phase != 2 && k < 200) begin
      run_cycles(1, 50, 50, 70, 0, 0, 1'b0);
      k++;
    end
    check_val("reach_load_wait", (m_phase == 2), 1'b1);
    do_reset();
    // Data for the dropped load now arrives and must be ignored.
    run_cycles(100, 30, 30, 60, 60, 0, 1'b0);

    // Both requesters ask continuously and memory is always ready.
    do_reset();
    c_active = 1'b1; d_active = 1'b1; core_req = 1'b1; dbg_req = 1'b1;
    mem_ready = 1'b1; mem_rvalid = 1'b1;
    core_run = 0; dbg_seen = 0;
    run_cycles(300, 100, 100, 100, 100, 0, 1'b1);
    check_val("starve_dbg_grants", (dbg_seen >= 3), 1'b1);

    // Return to random traffic.
    run_cycles(500, 40, 40, 50, 30, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
